// File: rtl/uart_packet_rx.sv
// UART 8N1 receiver feeding a framed host-packet decoder (header, payload, XOR checksum).
// Accepted packets are published through shadow registers that only change on pkt_valid.
module uart_packet_rx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int MAX_PAYLOAD  = 8,
   parameter int TIMEOUT_CLKS = 20*CLKS_PER_BIT
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               rx,
   output logic                               pkt_valid,
   output logic                               pkt_error,
   output logic [2:0]                         err_code,
   output logic                               rw_flag,
   output logic                               target_mem_type,
   output logic [8:0]                         target_addr,
   output logic [$clog2(MAX_PAYLOAD+1)-1:0]   byte_count,
   output logic [8*MAX_PAYLOAD-1:0]           data_out
);

   localparam int CW   = $clog2(MAX_PAYLOAD+1);
   localparam int BW   = $clog2(CLKS_PER_BIT);
   localparam int TW   = $clog2(TIMEOUT_CLKS+1);
   localparam int HALF = CLKS_PER_BIT/2;
   localparam logic [5:0] MAXP = 6'(MAX_PAYLOAD);

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
   } rx_state_t;

   typedef enum logic [2:0] {
      S_HDR0, S_HDR1, S_PAYLOAD, S_CSUM, S_FLUSH
   } pkt_state_t;

   // ---------------- bit engine ----------------
   logic            rx_s1, rx_s2;
   rx_state_t       rx_state, rx_state_next;
   logic [BW-1:0]   bit_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift_r;
   logic            byte_done;
   logic [7:0]      byte_data;
   logic            stop_ok;
   logic            bit_tick, half_tick;

   assign bit_tick  = (bit_cnt == BW'(CLKS_PER_BIT-1));
   assign half_tick = (bit_cnt == BW'(HALF-1));

   always_comb begin
      rx_state_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (!rx_s2) rx_state_next = RX_START;
         RX_START: if (half_tick) rx_state_next = rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (bit_tick && bit_idx == 3'd7) rx_state_next = RX_STOP;
         RX_STOP:  if (bit_tick) rx_state_next = rx_s2 ? RX_IDLE : RX_WAIT;
         RX_WAIT:  if (rx_s2) rx_state_next = RX_IDLE;
         default:  rx_state_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         rx_state  <= RX_IDLE;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         shift_r   <= '0;
         byte_done <= 1'b0;
         byte_data <= '0;
         stop_ok   <= 1'b0;
      end else begin
         rx_s1     <= rx;
         rx_s2     <= rx_s1;
         rx_state  <= rx_state_next;
         byte_done <= 1'b0;
         // bit timer restarts on every state change so samples land on bit centres
         if (rx_state_next != rx_state || bit_tick)
            bit_cnt <= '0;
         else if (rx_state == RX_START || rx_state == RX_DATA || rx_state == RX_STOP)
            bit_cnt <= bit_cnt + 1'b1;
         if (rx_state == RX_START)
            bit_idx <= '0;
         if (rx_state == RX_DATA && bit_tick) begin
            shift_r <= {rx_s2, shift_r[7:1]};
            bit_idx <= bit_idx + 1'b1;
         end
         if (rx_state == RX_STOP && bit_tick) begin
            byte_done <= 1'b1;
            byte_data <= shift_r;
            stop_ok   <= rx_s2;
         end
      end
   end

   // ---------------- packet decoder ----------------
   pkt_state_t              state, state_next;
   logic                    rw_r, mem_r;
   logic [4:0]              len_m1_r;
   logic [8:0]              addr_r;
   logic [7:0]              csum_r;
   logic [CW-1:0]           idx_r;
   logic [8*MAX_PAYLOAD-1:0] buf_r;
   logic [TW-1:0]           idle_cnt;
   logic                    counting, expired;
   logic                    set_valid, set_error;
   logic [2:0]              err_next;
   logic                    good_byte;

   assign good_byte = byte_done && stop_ok;
   assign counting  = (state == S_HDR1) || (state == S_PAYLOAD) ||
                      (state == S_CSUM) || (state == S_FLUSH);
   assign expired   = counting && !byte_done && (idle_cnt == TW'(TIMEOUT_CLKS-1));

   always_comb begin
      state_next = state;
      set_valid  = 1'b0;
      set_error  = 1'b0;
      err_next   = err_code;
      if (byte_done && !stop_ok) begin
         if (state != S_FLUSH) begin
            set_error = 1'b1;
            err_next  = 3'd1;
         end
         state_next = S_FLUSH;
      end else if (byte_done) begin
         case (state)
            S_HDR0: begin
               if (byte_data[7] && ({1'b0, byte_data[5:1]} >= MAXP)) begin
                  set_error  = 1'b1;
                  err_next   = 3'd2;
                  state_next = S_FLUSH;
               end else begin
                  state_next = S_HDR1;
               end
            end
            S_HDR1:    state_next = rw_r ? S_PAYLOAD : S_CSUM;
            S_PAYLOAD: if (6'(idx_r) == {1'b0, len_m1_r}) state_next = S_CSUM;
            S_CSUM: begin
               if (csum_r == byte_data) begin
                  set_valid = 1'b1;
               end else begin
                  set_error = 1'b1;
                  err_next  = 3'd3;
               end
               state_next = S_HDR0;
            end
            S_FLUSH:   state_next = S_FLUSH;
            default:   state_next = S_HDR0;
         endcase
      end else if (expired) begin
         if (state != S_FLUSH) begin
            set_error = 1'b1;
            err_next  = 3'd4;
         end
         state_next = S_HDR0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= S_HDR0;
         rw_r            <= 1'b0;
         mem_r           <= 1'b0;
         len_m1_r        <= '0;
         addr_r          <= '0;
         csum_r          <= '0;
         idx_r           <= '0;
         buf_r           <= '0;
         idle_cnt        <= '0;
         pkt_valid       <= 1'b0;
         pkt_error       <= 1'b0;
         err_code        <= '0;
         rw_flag         <= 1'b0;
         target_mem_type <= 1'b0;
         target_addr     <= '0;
         byte_count      <= '0;
         data_out        <= '0;
      end else begin
         state     <= state_next;
         pkt_valid <= set_valid;
         pkt_error <= set_error;
         err_code  <= err_next;

         if (byte_done || !counting || state_next != state)
            idle_cnt <= '0;
         else
            idle_cnt <= idle_cnt + 1'b1;

         if (good_byte) begin
            case (state)
               S_HDR0: begin
                  rw_r     <= byte_data[7];
                  mem_r    <= byte_data[6];
                  len_m1_r <= byte_data[5:1];
                  addr_r   <= {byte_data[0], 8'h00};
                  csum_r   <= byte_data;
                  idx_r    <= '0;
                  buf_r    <= '0;
               end
               S_HDR1: begin
                  addr_r[7:0] <= byte_data;
                  csum_r      <= csum_r ^ byte_data;
               end
               S_PAYLOAD: begin
                  for (int unsigned k = 0; k < MAX_PAYLOAD; k++)
                     if (idx_r == CW'(k))
                        buf_r[8*(MAX_PAYLOAD-1-k) +: 8] <= byte_data;
                  idx_r  <= idx_r + 1'b1;
                  csum_r <= csum_r ^ byte_data;
               end
               default: ;
            endcase
         end

         if (set_valid) begin
            rw_flag         <= rw_r;
            target_mem_type <= mem_r;
            target_addr     <= addr_r;
            byte_count      <= rw_r ? CW'({1'b0, len_m1_r} + 6'd1) : '0;
            data_out        <= buf_r;
         end
      end
   end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Scoreboard bench for uart_packet_rx: directed packets push expected pulses,
// a monitor pops and compares whenever pkt_valid or pkt_error fires.
module tb_uart_packet_rx;

   localparam int CPB = 4;
   localparam int MAXP = 8;
   localparam int TO  = 80;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rx = 1'b1;
   logic        pkt_valid, pkt_error, rw_flag, target_mem_type;
   logic [2:0]  err_code;
   logic [8:0]  target_addr;
   logic [3:0]  byte_count;
   logic [63:0] data_out;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit          err;
      logic [2:0]  code;
      logic        rw;
      logic        mem;
      logic [8:0]  addr;
      logic [3:0]  cnt;
      logic [63:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t shadow;

   uart_packet_rx #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(MAXP), .TIMEOUT_CLKS(TO)) dut (
      .clk(clk), .reset(reset), .rx(rx),
      .pkt_valid(pkt_valid), .pkt_error(pkt_error), .err_code(err_code),
      .rw_flag(rw_flag), .target_mem_type(target_mem_type), .target_addr(target_addr),
      .byte_count(byte_count), .data_out(data_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(posedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(posedge clk);
      rx = 1'b1;
      repeat (CPB) @(posedge clk);
   endtask

   task automatic expect_good(input logic rw, input logic mem, input logic [8:0] addr,
                              input logic [3:0] cnt, input logic [63:0] data);
      exp_t e;
      e.err = 1'b0; e.code = 3'd0; e.rw = rw; e.mem = mem;
      e.addr = addr; e.cnt = cnt; e.data = data;
      shadow = e;
      sb.push_back(e);
   endtask

   task automatic expect_err(input logic [2:0] code);
      exp_t e;
      e = shadow;
      e.err = 1'b1;
      e.code = code;
      sb.push_back(e);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, 64'(pkt_valid), 64'd0);
      check({tag, "_error"}, 64'(pkt_error), 64'd0);
      check({tag, "_err_code"}, 64'(err_code), 64'd0);
      check({tag, "_rw"}, 64'(rw_flag), 64'd0);
      check({tag, "_mem"}, 64'(target_mem_type), 64'd0);
      check({tag, "_addr"}, 64'(target_addr), 64'd0);
      check({tag, "_count"}, 64'(byte_count), 64'd0);
      check({tag, "_data"}, data_out, 64'd0);
   endtask

   task automatic send_test1(input logic [7:0] cs);
      send_byte(8'hC2, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'hAB, 1'b1);
      send_byte(8'hCD, 1'b1);
      send_byte(cs, 1'b1);
   endtask

   always @(negedge clk) begin
      if (reset && (pkt_valid || pkt_error)) begin
         check("exclusive", 64'(pkt_valid & pkt_error), 64'd0);
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: got valid=%0b error=%0b code=%0d expected none",
                     pkt_valid, pkt_error, err_code);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("kind", 64'(pkt_error), 64'(e.err));
            if (e.err) check("err_code", 64'(err_code), 64'(e.code));
            check("rw_flag", 64'(rw_flag), 64'(e.rw));
            check("mem_type", 64'(target_mem_type), 64'(e.mem));
            check("addr", 64'(target_addr), 64'(e.addr));
            check("byte_count", 64'(byte_count), 64'(e.cnt));
            check("data_out", data_out, e.data);
         end
      end
   end

   initial begin
      shadow = '{err: 1'b0, code: 3'd0, rw: 1'b0, mem: 1'b0, addr: 9'd0, cnt: 4'd0, data: 64'd0};
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      reset = 1'b1;
      repeat (10) @(posedge clk);

      // 1: write, 2 payload bytes
      expect_good(1'b1, 1'b1, 9'h034, 4'd2, 64'hABCD_0000_0000_0000);
      send_test1(8'h90);
      repeat (10) @(posedge clk);

      // 2: read
      expect_good(1'b0, 1'b0, 9'h1FF, 4'd0, 64'd0);
      send_byte(8'h01, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'hFE, 1'b1);
      repeat (10) @(posedge clk);

      // 3: bad checksum, shadows must hold read packet values
      expect_err(3'd3);
      send_test1(8'h91);
      repeat (120) @(posedge clk);

      // 4: length error then flush, timeout, then recovery
      expect_err(3'd2);
      send_byte(8'hD0, 1'b1);
      repeat (120) @(posedge clk);
      expect_err(3'd4);
      send_byte(8'hC2, 1'b1);
      repeat (120) @(posedge clk);
      expect_good(1'b1, 1'b1, 9'h034, 4'd2, 64'hABCD_0000_0000_0000);
      send_test1(8'h90);
      repeat (10) @(posedge clk);

      // 5: framing error, then a short glitch that must not start a byte
      expect_err(3'd1);
      send_byte(8'h55, 1'b0);
      repeat (120) @(posedge clk);
      rx = 1'b0;
      repeat (2) @(posedge clk);
      rx = 1'b1;
      repeat (60) @(posedge clk);
      expect_good(1'b0, 1'b0, 9'h1FF, 4'd0, 64'd0);
      send_byte(8'h01, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'hFE, 1'b1);
      repeat (10) @(posedge clk);

      // 6: reset after H1 aborts silently
      send_byte(8'hC2, 1'b1);
      send_byte(8'h34, 1'b1);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_zero_outputs("midreset");
      shadow = '{err: 1'b0, code: 3'd0, rw: 1'b0, mem: 1'b0, addr: 9'd0, cnt: 4'd0, data: 64'd0};
      reset = 1'b1;
      repeat (10) @(posedge clk);
      expect_good(1'b1, 1'b1, 9'h034, 4'd2, 64'hABCD_0000_0000_0000);
      send_test1(8'h90);

      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
      repeat (20) @(posedge clk);
      check("pending_expected", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
